// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared grant/owner types and VRAM geometry for the VRAM arbiter.
package vram_arb_pkg;
  typedef enum logic [1:0] {GRANT_NONE = 2'd0, GRANT_DISP = 2'd1, GRANT_CPU = 2'd2} vram_grant_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU} vram_owner_t;
  localparam int VRAM_WORDS = 76800;
  // Writes complete at grant, so only reads claim a response slot.
  function automatic vram_owner_t owner_of(vram_grant_t g, logic we);
    return g == GRANT_DISP ? OWN_DISP : (g == GRANT_CPU && !we) ? OWN_CPU : OWN_NONE;
  endfunction
endpackage

// File: rtl/vram_rsp_pipe.sv
// vram_rsp_pipe: two-stage read response pipeline routing RAM data back to its owner.
module vram_rsp_pipe
  import vram_arb_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  vram_grant_t       i_grant,
  input  logic              i_cpu_we,
  input  logic [DATA_W-1:0] i_ram_rd_data,
  output logic              o_disp_rsp_valid,
  output logic [DATA_W-1:0] o_disp_rsp_data,
  output logic              o_cpu_rsp_valid,
  output logic [DATA_W-1:0] o_cpu_rsp_data
);
  vram_owner_t r_owner;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner          <= OWN_NONE;
      o_disp_rsp_valid <= 1'b0;
      o_cpu_rsp_valid  <= 1'b0;
      o_disp_rsp_data  <= '0;
      o_cpu_rsp_data   <= '0;
    end else begin
      r_owner          <= owner_of(i_grant, i_cpu_we);
      o_disp_rsp_valid <= r_owner == OWN_DISP;
      o_cpu_rsp_valid  <= r_owner == OWN_CPU;
      if (r_owner == OWN_DISP) o_disp_rsp_data <= i_ram_rd_data;
      if (r_owner == OWN_CPU) o_cpu_rsp_data <= i_ram_rd_data;
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM sharing between display scanout and CPU with
// display priority and a bounded CPU wait.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 16,
  parameter int MAX_CPU_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req_valid,
  output logic              disp_req_ready,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rsp_valid,
  output logic [DATA_W-1:0] disp_rsp_data,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rd_data
);
  logic [3:0]  r_cpu_wait_cnt;
  logic        w_sat;
  vram_grant_t w_grant;
  assign w_sat = r_cpu_wait_cnt == 4'(MAX_CPU_WAIT);
  // Display wins unless the CPU has waited its full budget.
  always_comb begin
    w_grant = rst ? GRANT_NONE :
              (disp_req_valid && !(cpu_req_valid && w_sat)) ? GRANT_DISP :
              cpu_req_valid ? GRANT_CPU : GRANT_NONE;
  end
  assign disp_req_ready = w_grant == GRANT_DISP;
  assign cpu_req_ready  = w_grant == GRANT_CPU;
  assign ram_addr  = w_grant == GRANT_DISP ? disp_addr : w_grant == GRANT_CPU ? cpu_addr : '0;
  assign ram_we    = (w_grant == GRANT_CPU) & cpu_we;
  assign ram_wdata = cpu_wdata;
  always_ff @(posedge clk) begin
    if (rst || !cpu_req_valid || w_grant == GRANT_CPU) r_cpu_wait_cnt <= '0;
    else if (!w_sat) r_cpu_wait_cnt <= r_cpu_wait_cnt + 4'd1;
  end
  vram_rsp_pipe #(.DATA_W(DATA_W)) u_rsp_pipe (
    .clk              (clk),
    .rst              (rst),
    .i_grant          (w_grant),
    .i_cpu_we         (cpu_we),
    .i_ram_rd_data    (ram_rd_data),
    .o_disp_rsp_valid (disp_rsp_valid),
    .o_disp_rsp_data  (disp_rsp_data),
    .o_cpu_rsp_valid  (cpu_rsp_valid),
    .o_cpu_rsp_data   (cpu_rsp_data)
  );
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench with a behavioural VRAM for vram_arbiter.
module tb_vram_arbiter;
  import vram_arb_pkg::*;
  logic        clk = 0;
  logic        rst = 1;
  logic        disp_req_valid = 0, disp_req_ready;
  logic [16:0] disp_addr = 0;
  logic        disp_rsp_valid;
  logic [15:0] disp_rsp_data;
  logic        cpu_req_valid = 0, cpu_req_ready;
  logic [16:0] cpu_addr = 0;
  logic        cpu_we = 0;
  logic [15:0] cpu_wdata = 0;
  logic        cpu_rsp_valid;
  logic [15:0] cpu_rsp_data;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rd_data;

  vram_arbiter #(.ADDR_W(17), .DATA_W(16), .MAX_CPU_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .disp_req_valid(disp_req_valid), .disp_req_ready(disp_req_ready), .disp_addr(disp_addr),
    .disp_rsp_valid(disp_rsp_valid), .disp_rsp_data(disp_rsp_data),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_addr(cpu_addr),
    .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:VRAM_WORDS-1];
  logic        fill_en = 0;
  logic [15:0] fill_off = 0;
  always @(posedge clk) begin
    if (fill_en) for (int i = 0; i < VRAM_WORDS; i++) mem[i] <= 16'(i) + fill_off;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rd_data <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int due; bit cpu; logic [15:0] data;} rsp_t;
  rsp_t q[$];
  int n_chk = 0, n_fail = 0;
  bit mon_en = 0;
  logic [15:0] exp_d = 0, exp_c = 0;

  always @(negedge clk) begin
    logic ed, ec;
    rsp_t e;
    if (mon_en) begin
      ed = 0;
      ec = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (e.cpu) begin ec = 1; exp_c = e.data; end
        else begin ed = 1; exp_d = e.data; end
      end
      n_chk += 4;
      if (disp_rsp_valid !== ed) begin n_fail++; $display("FAIL disp_rsp_valid cyc=%0d got=%b exp=%b", cyc, disp_rsp_valid, ed); end
      if (cpu_rsp_valid !== ec) begin n_fail++; $display("FAIL cpu_rsp_valid cyc=%0d got=%b exp=%b", cyc, cpu_rsp_valid, ec); end
      if (disp_rsp_data !== exp_d) begin n_fail++; $display("FAIL disp_rsp_data cyc=%0d got=%h exp=%h", cyc, disp_rsp_data, exp_d); end
      if (cpu_rsp_data !== exp_c) begin n_fail++; $display("FAIL cpu_rsp_data cyc=%0d got=%h exp=%h", cyc, cpu_rsp_data, exp_c); end
    end
  end

  task automatic step(input logic dv, input logic [16:0] da, input logic cv,
                      input logic [16:0] ca, input logic we, input logic [15:0] wd);
    @(posedge clk);
    #1;
    disp_req_valid = dv; disp_addr = da;
    cpu_req_valid = cv; cpu_addr = ca; cpu_we = we; cpu_wdata = wd;
    @(negedge clk);
  endtask

  task automatic fill(input logic [15:0] off);
    fill_off = off;
    fill_en = 1;
    step(0, 0, 0, 0, 0, 0);
    fill_en = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q.size() > 0; i++) step(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (q.size() != 0) begin n_fail++; $display("FAIL drain pending=%0d exp=0", q.size()); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 17'd4, 1, 17'd8, 1, 16'h1234);
      n_chk += 4;
      if (disp_req_ready !== 0) begin n_fail++; $display("FAIL rst_disp_ready got=%b exp=0", disp_req_ready); end
      if (cpu_req_ready !== 0) begin n_fail++; $display("FAIL rst_cpu_ready got=%b exp=0", cpu_req_ready); end
      if (ram_we !== 0) begin n_fail++; $display("FAIL rst_ram_we got=%b exp=0", ram_we); end
      if (ram_addr !== 0) begin n_fail++; $display("FAIL rst_ram_addr got=%h exp=0", ram_addr); end
    end
    n_chk += 4;
    if (disp_rsp_valid !== 0) begin n_fail++; $display("FAIL rst_disp_rsp_valid got=%b exp=0", disp_rsp_valid); end
    if (cpu_rsp_valid !== 0) begin n_fail++; $display("FAIL rst_cpu_rsp_valid got=%b exp=0", cpu_rsp_valid); end
    if (disp_rsp_data !== 0) begin n_fail++; $display("FAIL rst_disp_rsp_data got=%h exp=0", disp_rsp_data); end
    if (cpu_rsp_data !== 0) begin n_fail++; $display("FAIL rst_cpu_rsp_data got=%h exp=0", cpu_rsp_data); end
    @(posedge clk);
    #1;
    rst = 0;
    disp_req_valid = 0; cpu_req_valid = 0; cpu_we = 0;
    mon_en = 1;
  endtask

  task automatic test_disp_only();
    fill(16'h100);
    for (int a = 0; a < 3; a++) begin
      step(1, 17'(a), 0, 0, 0, 0);
      n_chk += 3;
      if (disp_req_ready !== 1) begin n_fail++; $display("FAIL disp_only_ready a=%0d got=%b exp=1", a, disp_req_ready); end
      if (cpu_req_ready !== 0) begin n_fail++; $display("FAIL disp_only_cpu_ready a=%0d got=%b exp=0", a, cpu_req_ready); end
      if (ram_addr !== 17'(a)) begin n_fail++; $display("FAIL disp_only_addr got=%h exp=%h", ram_addr, a); end
      q.push_back('{cyc + 2, 1'b0, 16'h100 + 16'(a)});
    end
    drain();
  endtask

  task automatic test_contention();
    int mc = 0;
    bit ec;
    for (int i = 0; i < 15; i++) begin
      ec = (mc == 4);
      step(1, 17'd3, 1, 17'd7, 0, 0);
      n_chk += 3;
      if (disp_req_ready !== !ec) begin n_fail++; $display("FAIL cont_disp_ready i=%0d got=%b exp=%b", i, disp_req_ready, !ec); end
      if (cpu_req_ready !== ec) begin n_fail++; $display("FAIL cont_cpu_ready i=%0d got=%b exp=%b", i, cpu_req_ready, ec); end
      if (ram_addr !== (ec ? 17'd7 : 17'd3)) begin n_fail++; $display("FAIL cont_addr i=%0d got=%h exp=%h", i, ram_addr, ec ? 7 : 3); end
      q.push_back('{cyc + 2, ec, ec ? 16'h107 : 16'h103});
      mc = ec ? 0 : (mc == 4 ? 4 : mc + 1);
    end
    drain();
  endtask

  task automatic test_write_read();
    step(0, 0, 1, 17'h12C0, 1, 16'hBEEF);
    n_chk += 4;
    if (cpu_req_ready !== 1) begin n_fail++; $display("FAIL wr_ready got=%b exp=1", cpu_req_ready); end
    if (ram_we !== 1) begin n_fail++; $display("FAIL wr_ram_we got=%b exp=1", ram_we); end
    if (ram_addr !== 17'h12C0) begin n_fail++; $display("FAIL wr_addr got=%h exp=12c0", ram_addr); end
    if (ram_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr_wdata got=%h exp=beef", ram_wdata); end
    step(0, 0, 1, 17'h12C0, 0, 16'h0);
    n_chk += 2;
    if (cpu_req_ready !== 1) begin n_fail++; $display("FAIL rd_ready got=%b exp=1", cpu_req_ready); end
    if (ram_we !== 0) begin n_fail++; $display("FAIL rd_ram_we got=%b exp=0", ram_we); end
    q.push_back('{cyc + 2, 1'b1, 16'hBEEF});
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      n_chk++;
      if (ram_we !== 0) begin n_fail++; $display("FAIL wr_after_we got=%b exp=0", ram_we); end
    end
    drain();
  endtask

  task automatic test_routing();
    fill(16'h0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) step(1, 17'd5, 0, 0, 0, 0);
      else step(0, 0, 1, 17'd9, 0, 0);
      q.push_back('{cyc + 2, i % 2 == 1, i % 2 == 1 ? 16'd9 : 16'd5});
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    step(0, 0, 1, 17'd9, 0, 0);
    n_chk++;
    if (cpu_req_ready !== 1) begin n_fail++; $display("FAIL mid_ready got=%b exp=1", cpu_req_ready); end
    q.push_back('{cyc + 2, 1'b1, 16'd9});
    @(posedge clk);
    #1;
    rst = 1;
    cpu_req_valid = 0;
    @(negedge clk);
    #1;
    q.delete();
    exp_d = 0;
    exp_c = 0;
    step(1, 17'd2, 1, 17'd3, 1, 16'h55);
    n_chk += 4;
    if (disp_req_ready !== 0) begin n_fail++; $display("FAIL mid_rst_disp_ready got=%b exp=0", disp_req_ready); end
    if (cpu_req_ready !== 0) begin n_fail++; $display("FAIL mid_rst_cpu_ready got=%b exp=0", cpu_req_ready); end
    if (ram_we !== 0) begin n_fail++; $display("FAIL mid_rst_ram_we got=%b exp=0", ram_we); end
    if (ram_addr !== 0) begin n_fail++; $display("FAIL mid_rst_ram_addr got=%h exp=0", ram_addr); end
    @(posedge clk);
    #1;
    rst = 0;
    disp_req_valid = 0; cpu_req_valid = 0; cpu_we = 0;
    @(negedge clk);
    n_chk += 4;
    if (disp_req_ready !== 0) begin n_fail++; $display("FAIL post_rst_disp_ready got=%b exp=0", disp_req_ready); end
    if (cpu_req_ready !== 0) begin n_fail++; $display("FAIL post_rst_cpu_ready got=%b exp=0", cpu_req_ready); end
    if (ram_we !== 0) begin n_fail++; $display("FAIL post_rst_ram_we got=%b exp=0", ram_we); end
    if (ram_addr !== 0) begin n_fail++; $display("FAIL post_rst_ram_addr got=%h exp=0", ram_addr); end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_idle();
    step(1, 17'd5, 0, 0, 0, 0);
    q.push_back('{cyc + 2, 1'b0, 16'd5});
    step(0, 0, 1, 17'd9, 0, 0);
    q.push_back('{cyc + 2, 1'b1, 16'd9});
    drain();
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0, 0);
      n_chk += 4;
      if (ram_we !== 0) begin n_fail++; $display("FAIL idle_ram_we i=%0d got=%b exp=0", i, ram_we); end
      if (ram_addr !== 0) begin n_fail++; $display("FAIL idle_ram_addr i=%0d got=%h exp=0", i, ram_addr); end
      if (disp_req_ready !== 0) begin n_fail++; $display("FAIL idle_disp_ready i=%0d got=%b exp=0", i, disp_req_ready); end
      if (cpu_req_ready !== 0) begin n_fail++; $display("FAIL idle_cpu_ready i=%0d got=%b exp=0", i, cpu_req_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_disp_only();
    test_contention();
    test_write_read();
    test_routing();
    test_reset_midflight();
    test_idle();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port synchronous VRAM between two requesters: the display scanout (read-only, latency-tolerant but steady) and the CPU memory bus (reads and writes). It grants at most one access per cycle. Display reads normally win, and a bounded-wait counter guarantees CPU progress. Read data is routed back to the correct requester through a 2-cycle registered response pipeline. The block sits between the MMU VRAM bank decode and the display peripheral's `vram_rd_addr`/`vram_rd_data` path.

## Interface
- `ADDR_W`, 17, VRAM word address width (240*320 words).
- `DATA_W`, 16, VRAM word width (RGB565).
- `MAX_CPU_WAIT`, 4, consecutive CPU-blocked cycles before the CPU is forced a grant; range 1..15.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `disp_req_valid`  in  1  display read request.
- `disp_req_ready`  out  1  display request accepted this cycle.
- `disp_addr`  in  ADDR_W  display read address.
- `disp_rsp_valid`  out  1  one-cycle pulse: `disp_rsp_data` updated.
- `disp_rsp_data`  out  DATA_W  last display read data, held until the next display response.
- `cpu_req_valid`  in  1  CPU request.
- `cpu_req_ready`  out  1  CPU request accepted this cycle.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_rsp_valid`  out  1  one-cycle pulse for a CPU read response.
- `cpu_rsp_data`  out  DATA_W  last CPU read data, held until the next CPU response.
- `ram_addr`  out  ADDR_W  VRAM address.
- `ram_we`  out  1  VRAM write enable.
- `ram_wdata`  out  DATA_W  VRAM write data.
- `ram_rd_data`  in  DATA_W  VRAM read data, valid the cycle after the address is presented.

## Operation
- **Grant (combinational, per cycle):** `grant` ∈ {NONE, DISP, CPU}.
  - Only one requester valid: that requester is granted.
  - Both valid: DISP is granted unless `cpu_wait_cnt == MAX_CPU_WAIT`, in which case CPU is granted.
  - Neither valid: NONE.
- **Ready signals:** `disp_req_ready = (grant==DISP)` and `cpu_req_ready = (grant==CPU)`.
  - Ready may depend combinationally on valid.
  - Requesters hold address and data stable while valid and not ready.
- **RAM mux:**
  - `ram_addr` follows the granted requester's address; it is 0 when NONE.
  - `ram_we = (grant==CPU) & cpu_we`.
  - `ram_wdata = cpu_wdata` always.
- **Starvation counter `cpu_wait_cnt`** (4 bits):
  - Increments when `cpu_req_valid & grant!=CPU`, saturating at `MAX_CPU_WAIT`.
  - Clears to 0 when the CPU is granted or `cpu_req_valid` is low.
- **Response pipeline:**
  - Stage 1 register `rsp_owner` ← {NONE, DISP, CPU_RD} from the grant. A CPU write records NONE.
  - In the next cycle, the stage 2 registers capture `ram_rd_data` into the owner's data register and pulse the owner's `*_rsp_valid`.
- **Write completion:** a CPU write completes at grant and produces no response.
- **No forwarding:** a read granted the cycle after a write to the same address returns the new data, by RAM ordering.

## Timing
- **Read latency:** grant in cycle N → `*_rsp_valid` high and data visible in cycle N+2.
- **Throughput:** one access per cycle, fully pipelined. Back-to-back grants give back-to-back responses in grant order.
- **Reset values:**
  - `disp_req_ready` = `cpu_req_ready` = 0 while `rst`.
  - `ram_we` = 0 and `ram_addr` = 0.
  - Both `rsp_valid` = 0 and both `rsp_data` = 0.
  - `cpu_wait_cnt` = 0 and `rsp_owner` = NONE.
- **Reset mid-operation:** in-flight responses are dropped, with no `rsp_valid` after `rst` deasserts. Data registers clear to 0.
- **Simultaneous requests with a saturated counter:** CPU wins for exactly one cycle. The counter clears, so DISP wins the following cycle.
- **Display worst-case wait:** 1 cycle after each forced CPU grant.
- **CPU worst-case wait:** `MAX_CPU_WAIT` cycles.

## Structure
- **Shared package `vram_arb_pkg`:**
  - enum `vram_grant_t` {GRANT_NONE=0, GRANT_DISP=1, GRANT_CPU=2}.
  - enum `vram_owner_t` {OWN_NONE, OWN_DISP, OWN_CPU}.
  - Localparam `VRAM_WORDS = 76800`.
- **Sub-module `vram_rsp_pipe`:** the owner register plus the two held data registers and valid pulses. Its inputs are `grant`, `cpu_we` and `ram_rd_data`.
- **Arbiter top:** grant logic, counter and RAM mux.

## Test plan
- **Display only:** `disp_req_valid` held 1 with addresses 0,1,2 and the RAM preloaded with `addr+16'h100` → ready every cycle; `disp_rsp_data` = 16'h100, 16'h101, 16'h102 in cycles 2,3,4.
- **Contention:** both valid continuously, `MAX_CPU_WAIT=4` → grant pattern DISP×4, CPU, DISP×4, CPU… and `cpu_wait_cnt` never exceeds 4.
- **Write then read:** CPU writes 16'hBEEF to 0x12C0, then reads 0x12C0 → `ram_we` is pulsed once; `cpu_rsp_data` = 16'hBEEF two cycles after the read grant; no `disp_rsp_valid`.
- **Response routing:** alternating DISP read of 5 and CPU read of 9 with the RAM = addr → `disp_rsp_data` = 5 and `cpu_rsp_data` = 9; each valid pulses only for its owner, and held data is unchanged by the other owner's responses.
- **Reset mid-flight:** assert `rst` in the cycle after a CPU read grant → no `cpu_rsp_valid` ever appears; all outputs are 0 during reset and in the first cycle after it.
- **Idle:** no valids for 10 cycles → `ram_we` = 0, `ram_addr` = 0, no `rsp_valid`, and held data is unchanged.
